// File: rtl/rv32im_pc_ctrl_if.sv
// Instruction-memory request channel between the PC sequencer (master) and memory (slave).
// Handshake: a request is accepted in any cycle where imem_req_o and imem_gnt_i are both high;
// imem_rvalid_i returns exactly one response per accepted request, no earlier than the next cycle.
interface rv32im_pc_ctrl_if #(
   parameter int API_ADDR_WIDTH = 32
);
   logic                      imem_req_o;
   logic [API_ADDR_WIDTH-1:0] imem_addr_o;
   logic                      imem_gnt_i;
   logic                      imem_rvalid_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i
   );
endinterface

// File: rtl/rv32im_pc_ctrl.sv
// Front-end PC sequencer: one outstanding fetch, branch redirect with wrong-path squash,
// and misaligned-target reporting.
module rv32im_pc_ctrl #(
   parameter int                        API_ADDR_WIDTH = 32,
   parameter logic [API_ADDR_WIDTH-1:0] RESET_VECTOR   = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      stall_i,
   input  logic                      br_valid_i,
   input  logic                      br_taken_i,
   input  logic [API_ADDR_WIDTH-1:0] br_pc_i,
   rv32im_pc_ctrl_if.master          imem,
   output logic                      if_valid_o,
   output logic [API_ADDR_WIDTH-1:0] if_pc_o,
   output logic                      flush_o,
   output logic                      misalign_o,
   output logic [1:0]                state_o
);

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   logic [1:0]                state_q, state_d;
   logic [API_ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [API_ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
   logic                      if_valid_q, if_valid_d;
   logic [API_ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
   logic                      flush_q, flush_d;
   logic                      misalign_q, misalign_d;

   logic br_hit, redirect, misalign, req, accept, resp;

   assign br_hit   = br_valid_i & br_taken_i;
   assign redirect = br_hit & (br_pc_i[1:0] == 2'b00);
   assign misalign = br_hit & (br_pc_i[1:0] != 2'b00);
   // A held instruction with stall low is consumed this cycle, so only stall gates the
   // request; this lets the next fetch overlap delivery (one instruction per two cycles).
   assign req      = (state_q == ST_FETCH) & ~stall_i;
   assign accept   = req & imem.imem_gnt_i;
   assign resp     = imem.imem_rvalid_i;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      if_pc_d    = if_pc_q;
      if_valid_d = if_valid_q & stall_i;
      flush_d    = redirect;
      misalign_d = misalign;

      case (state_q)
         ST_BOOT: state_d = ST_FETCH;
         ST_FETCH: begin
            if (accept) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + API_ADDR_WIDTH'(4);
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (resp) begin
               state_d = ST_FETCH;
               if (!redirect) begin
                  if_valid_d = 1'b1;
                  if_pc_d    = req_pc_q;
               end
            end
         end
         ST_DRAIN: begin
            if (resp) state_d = ST_FETCH;
         end
         default: state_d = ST_BOOT;
      endcase

      // Redirect: anything still in flight for the old path must be drained before refetching.
      if (redirect) begin
         pc_d       = br_pc_i;
         if_valid_d = 1'b0;
         if ((state_q == ST_WAIT || state_q == ST_DRAIN) && !resp)
            state_d = ST_DRAIN;
         else if (state_q == ST_FETCH && accept)
            state_d = ST_DRAIN;
         else
            state_d = ST_FETCH;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VECTOR;
         req_pc_q   <= RESET_VECTOR;
         if_valid_q <= 1'b0;
         if_pc_q    <= RESET_VECTOR;
         flush_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         flush_q    <= flush_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem.imem_req_o  = req;
   assign imem.imem_addr_o = pc_q;
   assign if_valid_o       = if_valid_q;
   assign if_pc_o          = if_pc_q;
   assign flush_o          = flush_q;
   assign misalign_o       = misalign_q;
   assign state_o          = state_q;

endmodule
